// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line.
// Sits between the IF stage and the instruction-fetch port of ram_control.
// Hits answer one cycle after the request; misses fetch a single word,
// fill the line and forward the word on the same edge.
module icache #(
  parameter int ADDR_BITS  = 18,
  parameter int INDEX_BITS = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rst_c,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_rdy_o,
  output logic [31:0] if_inst_o,
  output logic        mem_en_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_rdy_i,
  input  logic [31:0] mem_inst_i
);

  localparam int TAG_BITS = ADDR_BITS - INDEX_BITS - 2;
  localparam int LINES    = 1 << INDEX_BITS;

  typedef enum logic {
    S_IDLE,
    S_MISS
  } state_e;

  state_e state_q, state_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0] tag_q  [LINES];
  logic [31:0]         data_q [LINES];

  // Word address (byte-offset bits dropped) of the outstanding miss.
  logic [ADDR_BITS-3:0] miss_addr_q, miss_addr_d;

  logic        if_rdy_q, if_rdy_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        mem_en_q, mem_en_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic                  fill_we;
  logic [INDEX_BITS-1:0] req_idx, fill_idx;
  logic [TAG_BITS-1:0]   req_tag, fill_tag;
  logic                  hit;

  // Byte-offset bits never take part in lookup or fetch.
  logic unused_byte_offset;
  assign unused_byte_offset = ^if_addr_i[1:0];

  assign req_idx  = if_addr_i[INDEX_BITS+1:2];
  assign req_tag  = if_addr_i[ADDR_BITS-1:INDEX_BITS+2];
  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  assign fill_idx = miss_addr_q[INDEX_BITS-1:0];
  assign fill_tag = miss_addr_q[ADDR_BITS-3:INDEX_BITS];

  assign if_rdy_o   = if_rdy_q;
  assign if_inst_o  = if_inst_q;
  assign mem_en_o   = mem_en_q;
  assign mem_addr_o = mem_addr_q;

  // Next-state and output logic: flush beats stall, stall freezes everything.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    if_rdy_d    = if_rdy_q;
    if_inst_d   = if_inst_q;
    mem_en_d    = mem_en_q;
    mem_addr_d  = mem_addr_q;
    fill_we     = 1'b0;

    if (rst_c) begin
      // Abort any in-flight miss; a same-cycle mem_rdy_i is dropped.
      state_d  = S_IDLE;
      if_rdy_d = 1'b0;
      mem_en_d = 1'b0;
    end else if (rdy) begin
      case (state_q)
        S_IDLE: begin
          if_rdy_d = 1'b0;
          if (if_req_i) begin
            if (hit) begin
              if_inst_d = data_q[req_idx];
              if_rdy_d  = 1'b1;
            end else begin
              miss_addr_d = if_addr_i[ADDR_BITS-1:2];
              mem_addr_d  = {if_addr_i[31:2], 2'b00};
              mem_en_d    = 1'b1;
              state_d     = S_MISS;
            end
          end
        end
        S_MISS: begin
          if_rdy_d = 1'b0;
          if (mem_rdy_i) begin
            // Drop the fetch enable on this edge so ram_control never
            // sees it still high when it re-samples after its ready pulse.
            fill_we   = 1'b1;
            if_inst_d = mem_inst_i;
            if_rdy_d  = 1'b1;
            mem_en_d  = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      miss_addr_q <= '0;
      if_rdy_q    <= 1'b0;
      if_inst_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if_rdy_q    <= if_rdy_d;
      if_inst_q   <= if_inst_d;
      mem_en_q    <= mem_en_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Valid bits: cleared on reset, set by a completed fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_we) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag and data storage, written only by a fill; contents are don't-care
  // until the matching valid bit is set.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst_i;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed test for icache: cold miss, hits, conflict replacement,
// flush mid-miss, stall during miss, and async reset mid-miss.
module tb_icache;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        rst_c;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_rdy_o;
  logic [31:0] if_inst_o;
  logic        mem_en_o;
  logic [31:0] mem_addr_o;
  logic        mem_rdy_i;
  logic [31:0] mem_inst_i;

  int total = 0;
  int bad   = 0;

  icache #(.ADDR_BITS(18), .INDEX_BITS(7)) dut (
    .clk       (clk),
    .rst       (rst),
    .rdy       (rdy),
    .rst_c     (rst_c),
    .if_req_i  (if_req_i),
    .if_addr_i (if_addr_i),
    .if_rdy_o  (if_rdy_o),
    .if_inst_o (if_inst_o),
    .mem_en_o  (mem_en_o),
    .mem_addr_o(mem_addr_o),
    .mem_rdy_i (mem_rdy_i),
    .mem_inst_i(mem_inst_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst        = 1'b0;
    rdy        = 1'b1;
    rst_c      = 1'b0;
    if_req_i   = 1'b0;
    if_addr_i  = '0;
    mem_rdy_i  = 1'b0;
    mem_inst_i = '0;

    // Reset state
    tick();
    tick();
    check("rst_if_rdy",   {31'b0, if_rdy_o}, 32'h0);
    check("rst_if_inst",  if_inst_o,         32'h0);
    check("rst_mem_en",   {31'b0, mem_en_o}, 32'h0);
    check("rst_mem_addr", mem_addr_o,        32'h0);
    rst = 1'b1;
    tick();

    // Cold miss on 0x1000
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_1000;
    tick();
    check("cold_mem_en",   {31'b0, mem_en_o}, 32'h1);
    check("cold_mem_addr", mem_addr_o,        32'h0000_1000);
    check("cold_if_rdy",   {31'b0, if_rdy_o}, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("cold_wait_en",   {31'b0, mem_en_o}, 32'h1);
      check("cold_wait_addr", mem_addr_o,        32'h0000_1000);
      check("cold_wait_rdy",  {31'b0, if_rdy_o}, 32'h0);
    end
    mem_rdy_i  = 1'b1;
    mem_inst_i = 32'h0010_0093;
    tick();
    check("cold_fill_rdy",  {31'b0, if_rdy_o}, 32'h1);
    check("cold_fill_inst", if_inst_o,         32'h0010_0093);
    check("cold_fill_en",   {31'b0, mem_en_o}, 32'h0);

    // Hit on 0x1000
    mem_rdy_i  = 1'b0;
    mem_inst_i = 32'hDEAD_BEEF;
    if_addr_i  = 32'h0000_1000;
    tick();
    check("hit_rdy",  {31'b0, if_rdy_o}, 32'h1);
    check("hit_inst", if_inst_o,         32'h0010_0093);
    check("hit_en",   {31'b0, mem_en_o}, 32'h0);

    // Fill 0x1004 (index 1)
    if_addr_i = 32'h0000_1004;
    tick();
    check("m1004_en",   {31'b0, mem_en_o}, 32'h1);
    check("m1004_addr", mem_addr_o,        32'h0000_1004);
    check("m1004_rdy",  {31'b0, if_rdy_o}, 32'h0);
    mem_rdy_i  = 1'b1;
    mem_inst_i = 32'hAAAA_0001;
    tick();
    check("f1004_rdy",  {31'b0, if_rdy_o}, 32'h1);
    check("f1004_inst", if_inst_o,         32'hAAAA_0001);
    mem_rdy_i = 1'b0;

    // Back-to-back hits 0x1000 / 0x1004
    if_addr_i = 32'h0000_1000;
    tick();
    check("b2b0_rdy",  {31'b0, if_rdy_o}, 32'h1);
    check("b2b0_inst", if_inst_o,         32'h0010_0093);
    if_addr_i = 32'h0000_1004;
    tick();
    check("b2b1_rdy",  {31'b0, if_rdy_o}, 32'h1);
    check("b2b1_inst", if_inst_o,         32'hAAAA_0001);
    check("b2b1_en",   {31'b0, mem_en_o}, 32'h0);
    if_req_i = 1'b0;
    tick();
    check("idle_rdy",  {31'b0, if_rdy_o}, 32'h0);

    // Conflict: 0x1200 shares index 0 with 0x1000
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_1200;
    tick();
    check("c1200_en",   {31'b0, mem_en_o}, 32'h1);
    check("c1200_addr", mem_addr_o,        32'h0000_1200);
    mem_rdy_i  = 1'b1;
    mem_inst_i = 32'h1200_0013;
    tick();
    check("c1200_rdy",  {31'b0, if_rdy_o}, 32'h1);
    check("c1200_inst", if_inst_o,         32'h1200_0013);
    mem_rdy_i = 1'b0;
    if_addr_i = 32'h0000_1000;
    tick();
    check("c1000_en",   {31'b0, mem_en_o}, 32'h1);
    check("c1000_addr", mem_addr_o,        32'h0000_1000);
    check("c1000_rdy",  {31'b0, if_rdy_o}, 32'h0);
    mem_rdy_i  = 1'b1;
    mem_inst_i = 32'h0010_0093;
    tick();
    check("c1000_fill", if_inst_o,         32'h0010_0093);
    mem_rdy_i = 1'b0;
    if_req_i  = 1'b0;
    tick();

    // Flush mid-miss on 0x2000, with a stale mem_rdy_i
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_2000;
    tick();
    check("fl_en",   {31'b0, mem_en_o}, 32'h1);
    tick();
    rst_c      = 1'b1;
    mem_rdy_i  = 1'b1;
    mem_inst_i = 32'hBAD0_0BAD;
    tick();
    check("fl_en_drop", {31'b0, mem_en_o}, 32'h0);
    check("fl_rdy",     {31'b0, if_rdy_o}, 32'h0);
    rst_c    = 1'b0;
    if_req_i = 1'b0;
    tick();
    check("fl_stale_rdy", {31'b0, if_rdy_o}, 32'h0);
    check("fl_stale_en",  {31'b0, mem_en_o}, 32'h0);
    mem_rdy_i = 1'b0;
    if_req_i  = 1'b1;
    tick();
    check("fl_remiss_en",   {31'b0, mem_en_o}, 32'h1);
    check("fl_remiss_addr", mem_addr_o,        32'h0000_2000);
    mem_rdy_i  = 1'b1;
    mem_inst_i = 32'h2000_0013;
    tick();
    check("fl_fill_inst", if_inst_o, 32'h2000_0013);
    mem_rdy_i = 1'b0;
    if_req_i  = 1'b0;
    tick();

    // Stall during miss on 0x3000
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_3000;
    tick();
    check("st_en", {31'b0, mem_en_o}, 32'h1);
    rdy        = 1'b0;
    mem_rdy_i  = 1'b1;
    mem_inst_i = 32'h0000_0033;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("st_hold_en",  {31'b0, mem_en_o}, 32'h1);
      check("st_hold_rdy", {31'b0, if_rdy_o}, 32'h0);
    end
    rdy = 1'b1;
    tick();
    check("st_fill_rdy",  {31'b0, if_rdy_o}, 32'h1);
    check("st_fill_inst", if_inst_o,         32'h0000_0033);
    check("st_fill_en",   {31'b0, mem_en_o}, 32'h0);
    mem_rdy_i  = 1'b0;
    mem_inst_i = 32'h0;
    tick();
    check("st_hit_rdy",  {31'b0, if_rdy_o}, 32'h1);
    check("st_hit_inst", if_inst_o,         32'h0000_0033);
    if_req_i = 1'b0;
    tick();

    // Async reset mid-miss on 0x4000
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_4000;
    tick();
    check("ar_en", {31'b0, mem_en_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_en_clr",   {31'b0, mem_en_o}, 32'h0);
    check("ar_addr_clr", mem_addr_o,        32'h0);
    check("ar_inst_clr", if_inst_o,         32'h0);
    if_req_i = 1'b0;
    tick();
    rst        = 1'b1;
    mem_rdy_i  = 1'b1;
    mem_inst_i = 32'hBAD1_0BAD;
    tick();
    check("ar_stale_rdy", {31'b0, if_rdy_o}, 32'h0);
    mem_rdy_i = 1'b0;
    if_req_i  = 1'b1;
    if_addr_i = 32'h0000_3000;
    tick();
    check("ar_remiss_en",   {31'b0, mem_en_o}, 32'h1);
    check("ar_remiss_addr", mem_addr_o,        32'h0000_3000);
    check("ar_remiss_rdy",  {31'b0, if_rdy_o}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache.md
Name: icache

Overview:
- Direct-mapped, one-word-per-line instruction cache between the IF stage and ram_control's instruction-fetch port.
- Hits return the instruction one cycle after the request.
- Misses issue a single word fetch to ram_control, fill the line, then forward the word.
- Honours the global `rdy` stall and the `rst_c` pipeline flush.

Parameters:
- ADDR_BITS, 18: significant byte-address bits; bits [31:ADDR_BITS] ignored.
- INDEX_BITS, 7: line-index width; 2^INDEX_BITS lines of 32 bits; tag width = ADDR_BITS-INDEX_BITS-2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; 0 freezes all state and outputs.
- rst_c  in  1  pipeline flush (branch redirect); aborts an in-flight miss.
- if_req_i  in  1  IF fetch request.
- if_addr_i  in  32  IF fetch byte address, word aligned; bits [1:0] ignored.
- if_rdy_o  out  1  one-cycle pulse: if_inst_o valid.
- if_inst_o  out  32  fetched instruction.
- mem_en_o  out  1  fetch request to ram_control (inst_en_i).
- mem_addr_o  out  32  fetch address to ram_control (inst_addr_i).
- mem_rdy_i  in  1  ram_control inst_rdy_o pulse.
- mem_inst_i  in  32  ram_control inst_inst_o.

Behaviour:
- Address split:
  - index = addr[INDEX_BITS+1:2]
  - tag = addr[ADDR_BITS-1:INDEX_BITS+2]
  - hit = valid[index] && tag_ram[index]==tag.
- Storage per line: valid bit, tag, 32-bit data. Registered arrays; tag/data need no reset.
- Reset (rst=0, async):
  - state=IDLE; all valid bits=0.
  - if_rdy_o=0, if_inst_o=0, mem_en_o=0, mem_addr_o=0; latched miss address=0.
- Priority at each posedge: rst, then rst_c, then rdy=0 (hold everything), then FSM.
- rst_c=1 (with rdy ignored):
  - state=IDLE, if_rdy_o=0, mem_en_o=0.
  - No line fill; valid array untouched.
  - A mem_rdy_i arriving in the same cycle is discarded.
- FSM state IDLE:
  - if_req_i=1 and hit: if_inst_o<=data[index], if_rdy_o<=1, stay IDLE. Latency 1 cycle; back-to-back hits give one word per cycle.
  - if_req_i=1 and miss: latch address, mem_addr_o<={addr[31:2],2'b00}, mem_en_o<=1, if_rdy_o<=0, go MISS.
  - otherwise: if_rdy_o<=0.
- FSM state MISS:
  - if_rdy_o=0; mem_en_o and mem_addr_o held stable; if_req_i and if_addr_i ignored.
  - On mem_rdy_i=1:
    - write valid=1, tag and data (mem_inst_i) at the latched index, overwriting any old line;
    - if_inst_o<=mem_inst_i, if_rdy_o<=1, mem_en_o<=0, go IDLE.
  - mem_en_o must drop on that same edge. ram_control re-samples inst_en_i two cycles after its ready pulse, so this prevents a spurious refetch.
- Requester contract:
  - Holds if_req_i and if_addr_i stable until it sees if_rdy_o.
  - In the if_rdy_o cycle it presents the next address or drops if_req_i.
- if_rdy_o is always a single-cycle pulse per accepted request. It is never asserted outside IDLE→IDLE (hit) or MISS→IDLE (fill) transitions.
- Reset asserted mid-miss: everything clears immediately; a later mem_rdy_i is ignored because state is IDLE.
- Miss-path latency: 1 cycle (issue) + ram_control fetch time (6 cycles with 1-cycle RAM) + 0.
- No write path, no invalidate port; self-modifying code is unsupported.

Test Plan:
- Cold miss: reset, request 0x0000_1000; memory returns 0x0010_0093 → mem_en_o=1 with mem_addr_o=0x1000 until mem_rdy_i; if_rdy_o pulses one cycle later with 0x0010_0093; mem_en_o=0 in that cycle.
- Hit: re-request 0x1000 → if_rdy_o=1 next cycle, if_inst_o=0x0010_0093, mem_en_o stays 0. Back-to-back 0x1000/0x1004 (both filled) → two consecutive if_rdy_o pulses.
- Conflict: fill 0x1000, then request 0x1200 (same index, INDEX_BITS=7) → miss, line replaced; request 0x1000 again → miss again.
- Flush mid-miss: request 0x2000, pulse rst_c two cycles later → mem_en_o=0 and state IDLE the next cycle; stale mem_rdy_i is ignored, no if_rdy_o; request 0x2000 afterwards still misses.
- Stall: hold rdy=0 for 5 cycles while in MISS with mem_rdy_i=1 → no state change, no fill; release rdy → fill completes.
- Async reset: drop rst mid-miss between clock edges → outputs go to 0 immediately; after release, a previously filled address misses.
